nms_window_508: RTL and testbench

NMS_WINDOW_508 -- requirements
Module: nms_window_508

---
 rtl/nms_window_508.sv | 115 +++++++++++
 tb/tb_nms_window_508.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nms_window_508.sv
// Non-maximum suppression over a 3x3 magnitude window fed column-by-column from a line buffer.
// Optional low threshold on kept pixels is enabled by defining NMS_THRESH_EN.
module nms_window_508 #(
    parameter int          WIDTH  = 514,
    parameter int          HEIGHT = 480,
    parameter logic [19:0] THRESH = 20'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic        sof,
    input  logic [19:0] row_top,
    input  logic [19:0] row_mid,
    input  logic [19:0] row_bot,
    input  logic [1:0]  ang,
    output logic [19:0] edge_data,
    output logic        edge_valid,
    output logic        line_end,
    output logic        frame_end
);

    localparam int CW = (WIDTH  > 2) ? $clog2(WIDTH)  : 2;
    localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 2;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    // p1 = column c-1 (becomes the centre on the next load), p2 = column c-2
    logic [19:0]   top_p1_q, top_p2_q, mid_p1_q, mid_p2_q, bot_p1_q, bot_p2_q;
    logic [1:0]    ang_p1_q;
    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic [19:0]   edge_data_q, edge_data_d;
    logic          edge_valid_q, line_end_q, line_end_d, frame_end_q, frame_end_d;

    logic [19:0]   nb_a, nb_b, nms_val;
    logic          border;

    always_comb begin
        col_cur = sof ? '0 : col_q;
        row_cur = sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (ld) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
        end
    end

    // Window after this load: left = p2, centre = p1, right = incoming taps
    always_comb begin
        nb_a = mid_p2_q;
        nb_b = row_mid;
        case (ang_p1_q)
            2'd0: begin nb_a = mid_p2_q; nb_b = row_mid;  end
            2'd1: begin nb_a = row_top;  nb_b = bot_p2_q; end
            2'd2: begin nb_a = top_p1_q; nb_b = bot_p1_q; end
            default: begin nb_a = top_p2_q; nb_b = row_bot; end
        endcase

        border  = (col_cur < CW'(2)) || (row_cur < RW'(2));
        nms_val = ((mid_p1_q >= nb_a) && (mid_p1_q >= nb_b) && !border) ? mid_p1_q : 20'd0;
`ifdef NMS_THRESH_EN
        if (nms_val < THRESH) nms_val = 20'd0;
`endif

        edge_data_d = ld ? nms_val : edge_data_q;
        line_end_d  = ld && (col_cur == COL_LAST);
        frame_end_d = line_end_d && (row_cur == ROW_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_p1_q     <= '0;
            top_p2_q     <= '0;
            mid_p1_q     <= '0;
            mid_p2_q     <= '0;
            bot_p1_q     <= '0;
            bot_p2_q     <= '0;
            ang_p1_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            edge_data_q  <= '0;
            edge_valid_q <= 1'b0;
            line_end_q   <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            if (ld) begin
                top_p2_q <= top_p1_q;
                mid_p2_q <= mid_p1_q;
                bot_p2_q <= bot_p1_q;
                top_p1_q <= row_top;
                mid_p1_q <= row_mid;
                bot_p1_q <= row_bot;
                ang_p1_q <= ang;
            end
            col_q        <= col_d;
            row_q        <= row_d;
            edge_data_q  <= edge_data_d;
            edge_valid_q <= ld;
            line_end_q   <= line_end_d;
            frame_end_q  <= frame_end_d;
        end
    end

    assign edge_data  = edge_data_q;
    assign edge_valid = edge_valid_q;
    assign line_end   = line_end_q;
    assign frame_end  = frame_end_q;

endmodule

// File: tb/tb_nms_window_508.sv
// Bench for nms_window_508: directed window table, frame/sof/reset sequences, randomized run vs model.
module tb_nms_window_508;

    localparam int          W   = 8;
    localparam int          H   = 6;
    localparam logic [19:0] THR = 20'd60;
    localparam logic [19:0] F   = 20'd200;
`ifdef NMS_THRESH_EN
    localparam logic [19:0] EXP_C50 = 20'd0;
`else
    localparam logic [19:0] EXP_C50 = 20'd50;
`endif

    logic        clk = 1'b0, rst = 1'b1, ld = 1'b0, sof = 1'b0;
    logic [19:0] row_top = '0, row_mid = '0, row_bot = '0;
    logic [1:0]  ang = '0;
    logic [19:0] edge_data;
    logic        edge_valid, line_end, frame_end;

    nms_window_508 #(.WIDTH(W), .HEIGHT(H), .THRESH(THR)) dut (
        .clk(clk), .rst(rst), .ld(ld), .sof(sof),
        .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot), .ang(ang),
        .edge_data(edge_data), .edge_valid(edge_valid),
        .line_end(line_end), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    typedef struct { logic [19:0] t, m, b; logic [1:0] a; } pix_t;
    typedef struct {
        logic [19:0] tl, tc, tr, ml, mc, mr, bl, bc, br;
        logic [1:0]  a;
        logic [19:0] exp;
    } vec_t;

    pix_t        hist[$];
    int          pos = 0;
    logic [19:0] m_data = '0;
    logic        m_valid = 1'b0, m_line = 1'b0, m_frame = 1'b0;
    int          n_valid, n_line, n_frame, n_nz, frame_idx;
    vec_t        vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] rnd_mag();
        if ($urandom_range(0, 3) == 0) return 20'($urandom);
        return 20'($urandom_range(0, 7));
    endfunction

    // Reference: the last three accepted columns form the window, centre is the middle one
    function automatic logic [19:0] model_result(int col, int row);
        logic [19:0] w [3][3];
        logic [19:0] c, r;
        int ra, ka, rb, kb;
        if (col < 2 || row < 2 || hist.size() < 3) return 20'd0;
        for (int k = 0; k < 3; k++) begin
            w[0][k] = hist[k].t;
            w[1][k] = hist[k].m;
            w[2][k] = hist[k].b;
        end
        case (hist[1].a)
            2'd0:    begin ra = 1; ka = 0; rb = 1; kb = 2; end
            2'd1:    begin ra = 0; ka = 2; rb = 2; kb = 0; end
            2'd2:    begin ra = 0; ka = 1; rb = 2; kb = 1; end
            default: begin ra = 0; ka = 0; rb = 2; kb = 2; end
        endcase
        c = w[1][1];
        r = (c >= w[ra][ka] && c >= w[rb][kb]) ? c : 20'd0;
`ifdef NMS_THRESH_EN
        if (r < THR) r = 20'd0;
`endif
        return r;
    endfunction

    task automatic clr_counts();
        n_valid = 0; n_line = 0; n_frame = 0; n_nz = 0; frame_idx = -1;
    endtask

    task automatic step(input logic l, input logic s, input logic [19:0] t, input logic [19:0] m,
                        input logic [19:0] b, input logic [1:0] a);
        int cur, col, row;
        ld = l; sof = s; row_top = t; row_mid = m; row_bot = b; ang = a;
        @(posedge clk);
        #1;
        if (l) begin
            cur = s ? 0 : pos;
            col = cur % W;
            row = (cur / W) % H;
            hist.push_back('{t, m, b, a});
            if (hist.size() > 3) void'(hist.pop_front());
            m_data  = model_result(col, row);
            m_valid = 1'b1;
            m_line  = (col == W - 1);
            m_frame = m_line && (row == H - 1);
            pos     = (cur + 1) % (W * H);
        end else begin
            m_valid = 1'b0;
            m_line  = 1'b0;
            m_frame = 1'b0;
        end
        chk("edge_valid", 32'(edge_valid), 32'(m_valid));
        chk("edge_data",  32'(edge_data),  32'(m_data));
        chk("line_end",   32'(line_end),   32'(m_line));
        chk("frame_end",  32'(frame_end),  32'(m_frame));
        if (edge_valid) begin
            n_valid++;
            if (line_end) n_line++;
            if (frame_end) begin n_frame++; frame_idx = n_valid; end
            if (edge_data != 20'd0) n_nz++;
        end
        ld = 1'b0; sof = 1'b0;
    endtask

    // Called one time unit after a rising edge; reset pulse sits entirely between edges
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_edge_data",  32'(edge_data),  32'd0);
        chk("rst_edge_valid", 32'(edge_valid), 32'd0);
        chk("rst_line_end",   32'(line_end),   32'd0);
        chk("rst_frame_end",  32'(frame_end),  32'd0);
        pos = 0; m_data = '0; m_valid = 1'b0; m_line = 1'b0; m_frame = 1'b0;
        hist.delete();
        #2 rst = 1'b1;
    endtask

    task automatic apply_vec(input int i);
        step(1'b1, 1'b1, rnd_mag(), rnd_mag(), rnd_mag(), 2'($urandom_range(0, 3)));
        for (int k = 1; k < 2 * W; k++)
            step(1'b1, 1'b0, rnd_mag(), rnd_mag(), rnd_mag(), 2'($urandom_range(0, 3)));
        step(1'b1, 1'b0, vt[i].tl, vt[i].ml, vt[i].bl, 2'($urandom_range(0, 3)));
        step(1'b1, 1'b0, vt[i].tc, vt[i].mc, vt[i].bc, vt[i].a);
        step(1'b1, 1'b0, vt[i].tr, vt[i].mr, vt[i].br, 2'($urandom_range(0, 3)));
        chk($sformatf("vec%0d", i), 32'(edge_data), 32'(vt[i].exp));
        step(1'b0, 1'b0, rnd_mag(), rnd_mag(), rnd_mag(), 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          tl   tc    tr   ml           mc           mr    bl   bc   br   ang  exp
        vt[0]  = '{F,   F,    F,   20'd50,      20'd100,     20'd50,  F,    F,    F,   2'd0, 20'd100};
        vt[1]  = '{F,   F,    F,   20'd50,      20'd100,     20'd101, F,    F,    F,   2'd0, 20'd0};
        vt[2]  = '{F,   20'd120, F, F,          20'd100,     F,       F,    20'd50, F, 2'd2, 20'd0};
        vt[3]  = '{F,   20'd100, F, F,          20'd100,     F,       F,    20'd50, F, 2'd2, 20'd100};
        vt[4]  = '{F,   F,    20'd90, F,        20'd100,     F,       20'd99, F,  F,   2'd1, 20'd100};
        vt[5]  = '{F,   F,    20'd101, F,       20'd100,     F,       20'd0, F,   F,   2'd1, 20'd0};
        vt[6]  = '{20'd100, F, F,  F,           20'd100,     F,       F,    F,  20'd100, 2'd3, 20'd100};
        vt[7]  = '{20'd150, F, F,  F,           20'd100,     F,       F,    F,  20'd0,   2'd3, 20'd0};
        vt[8]  = '{20'd0, 20'd0, 20'd0, 20'd10, 20'd50,      20'd10,  20'd0, 20'd0, 20'd0, 2'd0, EXP_C50};
        vt[9]  = '{20'd0, 20'd0, 20'd0, 20'd10, 20'd70,      20'd10,  20'd0, 20'd0, 20'd0, 2'd0, 20'd70};
        vt[10] = '{20'd0, 20'd0, 20'd0, 20'd60, 20'd60,      20'd60,  20'd0, 20'd0, 20'd0, 2'd0, 20'd60};
        vt[11] = '{20'd0, 20'd0, 20'd0, 20'hFFFFF, 20'hFFFFF, 20'd0,  20'd0, 20'd0, 20'd0, 2'd0, 20'hFFFFF};

        #2 rst = 1'b0;
        #1;
        chk("init_edge_data",  32'(edge_data),  32'd0);
        chk("init_edge_valid", 32'(edge_valid), 32'd0);
        chk("init_line_end",   32'(line_end),   32'd0);
        chk("init_frame_end",  32'(frame_end),  32'd0);
        #5 rst = 1'b1;

        for (int i = 0; i < 12; i++) apply_vec(i);

        // Full frame of equal magnitudes, one pixel every other cycle
        clr_counts();
        for (int i = 0; i < W * H; i++) begin
            step(1'b1, i == 0, 20'd500, 20'd500, 20'd500, 2'($urandom_range(0, 3)));
            step(1'b0, 1'b0, 20'd0, 20'd0, 20'd0, 2'd0);
        end
        chk("frame_valid_cnt", 32'(n_valid), 32'd48);
        chk("frame_line_cnt",  32'(n_line),  32'd6);
        chk("frame_end_cnt",   32'(n_frame), 32'd1);
        chk("frame_end_idx",   32'(frame_idx), 32'd48);
        chk("frame_interior",  32'(n_nz),    32'd24);

        // sof restart at col 5 row 3; sof without ld must be ignored
        step(1'b1, 1'b1, 20'd500, 20'd500, 20'd500, 2'd0);
        for (int i = 1; i < 3 * W + 5; i++) begin
            step(1'b1, 1'b0, 20'd500, 20'd500, 20'd500, 2'd0);
            if (i == 10) step(1'b0, 1'b1, 20'd0, 20'd0, 20'd0, 2'd0);
        end
        clr_counts();
        step(1'b1, 1'b1, 20'd500, 20'd500, 20'd500, 2'd0);
        chk("sof_restart_data", 32'(edge_data), 32'd0);
        for (int i = 1; i < W * H; i++) step(1'b1, 1'b0, 20'd500, 20'd500, 20'd500, 2'd0);
        chk("sof_frame_end_cnt", 32'(n_frame), 32'd1);
        chk("sof_frame_end_idx", 32'(frame_idx), 32'd48);

        // Asynchronous reset mid-line, then a clean restart at col 0 row 0
        step(1'b1, 1'b1, 20'd500, 20'd500, 20'd500, 2'd0);
        for (int i = 1; i <= 2 * W + 4; i++) step(1'b1, 1'b0, 20'd500, 20'd500, 20'd500, 2'd0);
        chk("pre_reset_data", 32'(edge_data), 32'd500);
        do_reset();
        clr_counts();
        for (int i = 0; i < 2 * W; i++)
            step(1'b1, 1'b0, rnd_mag(), rnd_mag(), rnd_mag(), 2'($urandom_range(0, 3)));
        chk("post_reset_valid", 32'(n_valid), 32'd16);
        chk("post_reset_zeros", 32'(n_nz),    32'd0);

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                 rnd_mag(), rnd_mag(), rnd_mag(), 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
